key_pulse_conditioner: RTL and testbench
========================================

Name: key_pulse_conditioner

Overview:
- Upstream input stage for the DAC value controller: takes the 12 raw push-button lines (SM_1..SM_12) and conditions them.
- Conditioning is synchronise, debounce, then convert to single-cycle increment/decrement pulses, with optional auto-repeat while a key is held.
- Output key_pulse replaces raw key levels at the DAC value register, so one press produces exactly one step, not one step per 50 MHz clock.
- Debounced levels are also exported for the 7-segment/LCD status display.

Parameters:
- N_KEYS, 12, number of button inputs.
- TICK_CYCLES, 50000, clk cycles per 1 ms timebase tick (50 MHz).
- DEBOUNCE_MS, 20, ticks the synchronised input must differ from the stable state before the stable state flips.
- REPEAT_DELAY_MS, 500, ticks from press pulse to first repeat pulse.
- REPEAT_RATE_MS, 100, ticks between subsequent repeat pulses.
- REPEAT_MASK, 12'h2DA, per-key auto-repeat enable (default enables keys 1, 3, 4, 6, 7, 9).
- KEY_ACTIVE_LOW, 0, 1 = raw key reads 0 when pressed (inverted after the synchroniser).

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- key, input, N_KEYS, raw button levels, asynchronous to clk.
- key_pulse, output, N_KEYS, one-clk pulse per accepted press or repeat event.
- key_state, output, N_KEYS, debounced pressed level (1 = pressed).
- any_pulse, output, 1, OR of key_pulse, same cycle.

Behaviour:
- Reset is asynchronous and active-low; one clock domain (clk). On reset:
  - key_pulse, key_state and any_pulse are 0.
  - Synchroniser flops, debounce counters, repeat counters and tick prescaler are 0.
  - All channel FSMs are IDLE.
- Synchroniser: 2 flops per key, then optional inversion giving key_s.
- Tick: shared prescaler counts 0..TICK_CYCLES-1. tick = 1 for one clk when the count wraps to 0. Prescaler runs freely from reset.
- Debounce, per key:
  - If key_s == key_state, db_cnt is cleared.
  - Otherwise db_cnt increments on each tick.
  - When db_cnt reaches DEBOUNCE_MS on a tick, key_state toggles and db_cnt clears.
  - A glitch shorter than one tick never changes state. Any bounce back to the stable level clears the count.
- Channel FSM, per key; states IDLE, DELAY, REPEAT; rpt_cnt loaded on entry to DELAY or REPEAT.
  - IDLE: on key_state 0->1, pulse for 1 clk, go to DELAY if REPEAT_MASK bit set, else stay in HELD, a sub-case of DELAY in which the counter is disabled.
  - DELAY: rpt_cnt decrements on tick. At 0: pulse, reload REPEAT_RATE_MS, go to REPEAT.
  - REPEAT: rpt_cnt decrements on tick. At 0: pulse, reload REPEAT_RATE_MS.
  - Any state: key_state 1->0 returns to IDLE on the next clk with no pulse. Release has priority over an expiry in the same cycle.
- Pulses are registered outputs, exactly 1 clk wide, never on consecutive cycles for the same key.
- Press latency: 2 clk (sync) + DEBOUNCE_MS ticks (first tick quantised, 0..TICK_CYCLES-1 clk) + 1 clk.
- Simultaneous keys: channels are fully independent, and multiple key_pulse bits may assert in the same cycle. Priority resolution belongs to the consumer.
- Key held through reset release: key_state starts 0, so one press pulse is produced after debounce. This is intended behaviour.
- Counter widths: clog2 of the largest ms parameter + 1. Counters never wrap.
- Parameter constraints, checked with an elaboration-time check:
  - TICK_CYCLES >= 2.
  - DEBOUNCE_MS >= 1.
  - REPEAT_RATE_MS >= 1.

Decomposition:
- Package key_cond_pkg holds:
  - the channel state enum (IDLE/DELAY/REPEAT);
  - the default timing constants;
  - a clog2-based width function.
- One sub-module, key_channel: synchroniser, debounce counter and FSM for one key. It is instantiated N_KEYS times via generate, with the shared tick and per-key repeat enable as inputs.
- The tick prescaler and any_pulse OR live in the top.

Test Plan (bench overrides TICK_CYCLES=10, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5):
- Reset: assert rst_n=0 mid-run with keys pressed -> all outputs 0 immediately (async); after release, no pulse until 4 ticks of a stable press.
- Clean press: key[3] high for 300 clk -> exactly one key_pulse[3], 41..52 clk after the edge; key_state[3]=1 until 4 ticks after release.
- Bounce: key[1] toggling every 7 clk for 200 clk, then steady high -> zero pulses during the toggling, one pulse after the steady level holds 4 ticks.
- Auto-repeat: key[9] held 600 clk -> first pulse, next at +200 clk, then every 50 clk (pulse count 1+1+floor(remaining/50)); key[0] (mask 0) held the same time -> exactly one pulse.
- Release during DELAY: key[6] released 100 clk after the first pulse -> no further pulses; the FSM is back in IDLE after the debounce.
- Simultaneous: key[3] and key[4] pressed in the same cycle -> key_pulse = 12'h018 in a single cycle; any_pulse=1 for that cycle only.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types, default timing constants and counter sizing for the key conditioner.
// Imported by key_channel and key_pulse_conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } ch_state_e;

  localparam int unsigned DefNKeys         = 12;
  localparam int unsigned DefTickCycles    = 50000;
  localparam int unsigned DefDebounceMs    = 20;
  localparam int unsigned DefRepeatDelayMs = 500;
  localparam int unsigned DefRepeatRateMs  = 100;
  localparam logic [11:0] DefRepeatMask    = 12'h2DA;

  // One spare bit above the largest ms value so counters can never wrap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key lane: 2-flop synchroniser, tick-based debounce, and press/auto-repeat pulse FSM.
// Pulses are registered and one clk wide.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = DefDebounceMs,
  parameter int unsigned REPEAT_DELAY_MS = DefRepeatDelayMs,
  parameter int unsigned REPEAT_RATE_MS  = DefRepeatRateMs,
  parameter bit          KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic tick_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic state_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam logic [CntW-1:0] DbLast   = CntW'(DEBOUNCE_MS - 1);
  localparam logic [CntW-1:0] RptDelay = CntW'(REPEAT_DELAY_MS);
  localparam logic [CntW-1:0] RptRate  = CntW'(REPEAT_RATE_MS);

  logic [1:0]      sync_q;
  logic            key_s;
  logic [CntW-1:0] db_cnt_q;
  logic            state_q;
  ch_state_e       fsm_q, fsm_d;
  logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign key_s = sync_q[1] ^ KEY_ACTIVE_LOW;

  // Any sample agreeing with the stable level restarts the debounce count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      state_q  <= 1'b0;
    end else if (key_s == state_q) begin
      db_cnt_q <= '0;
    end else if (tick_i) begin
      if (db_cnt_q == DbLast) begin
        state_q  <= ~state_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    case (fsm_q)
      StIdle: begin
        if (state_q) begin
          pulse_d   = 1'b1;
          fsm_d     = StDelay;
          rpt_cnt_d = RptDelay;
        end
      end
      StDelay, StRepeat: begin
        // Release wins over a same-cycle expiry; without repeat enable DELAY just holds.
        if (!state_q) begin
          fsm_d = StIdle;
        end else if (repeat_en_i && tick_i) begin
          if (rpt_cnt_q <= CntW'(1)) begin
            pulse_d   = 1'b1;
            fsm_d     = StRepeat;
            rpt_cnt_d = RptRate;
          end else begin
            rpt_cnt_d = rpt_cnt_q - CntW'(1);
          end
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= StIdle;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign state_o = state_q;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Push-button front end: shared 1 ms tick prescaler feeding N_KEYS independent key channels.
// Exports single-cycle step pulses and debounced levels.
module key_pulse_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned        N_KEYS          = DefNKeys,
  parameter int unsigned        TICK_CYCLES     = DefTickCycles,
  parameter int unsigned        DEBOUNCE_MS     = DefDebounceMs,
  parameter int unsigned        REPEAT_DELAY_MS = DefRepeatDelayMs,
  parameter int unsigned        REPEAT_RATE_MS  = DefRepeatRateMs,
  parameter logic [N_KEYS-1:0]  REPEAT_MASK     = N_KEYS'(DefRepeatMask),
  parameter bit                 KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_state,
  output logic              any_pulse
);

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("TICK_CYCLES must be >= 2");
  end
  if (DEBOUNCE_MS < 1) begin : g_bad_db
    $error("DEBOUNCE_MS must be >= 1");
  end
  if (REPEAT_RATE_MS < 1) begin : g_bad_rate
    $error("REPEAT_RATE_MS must be >= 1");
  end

  localparam int unsigned PsW = $clog2(TICK_CYCLES);

  logic [PsW-1:0] ps_q;
  logic           tick;

  assign tick = (ps_q == PsW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else if (tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PsW'(1);
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_i      (key[i]),
      .tick_i     (tick),
      .repeat_en_i(REPEAT_MASK[i]),
      .pulse_o    (key_pulse[i]),
      .state_o    (key_state[i])
    );
  end

  assign any_pulse = |key_pulse;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Self-checking bench: time-window behavioural model compared every cycle, plus directed
// scenarios with hand-computed pulse counts and latencies, then randomized key activity.
module tb_key_pulse_conditioner;

  localparam int N  = 12;
  localparam int T  = 10;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam logic [11:0] MASK = 12'h2DA;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key;
  logic [N-1:0] key_pulse;
  logic [N-1:0] key_state;
  logic         any_pulse;

  key_pulse_conditioner #(
    .N_KEYS         (N),
    .TICK_CYCLES    (T),
    .DEBOUNCE_MS    (DB),
    .REPEAT_DELAY_MS(RD),
    .REPEAT_RATE_MS (RR),
    .REPEAT_MASK    (MASK),
    .KEY_ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_pulse(key_pulse),
    .key_state(key_state),
    .any_pulse(any_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: n = posedges since reset release; tick edges are multiples of T.
  int           n;
  logic [N-1:0] raw1, raw2, m_state, m_pulse, mask_v;
  int           last_agree[N];
  bit           pressed[N];
  int           press_n[N];

  // Observed pulse bookkeeping for directed scenarios.
  int           pcnt[N];
  int           t1[N], t2[N], t3[N];
  int           any_cnt;
  logic [N-1:0] any_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    int kt;
    logic [N-1:0] ks;
    if (!rst_n) begin
      n = 0; raw1 = '0; raw2 = '0; m_state = '0; m_pulse = '0;
      for (int k = 0; k < N; k++) begin
        last_agree[k] = 0; pressed[k] = 1'b0; press_n[k] = 0;
      end
    end else begin
      n++;
      tick = (n % T == 0);
      ks   = raw2;
      raw2 = raw1;
      raw1 = key;
      for (int k = 0; k < N; k++) begin
        logic old;
        logic p;
        old = m_state[k];
        p   = 1'b0;
        if (!old) begin
          pressed[k] = 1'b0;
        end else if (!pressed[k]) begin
          p = 1'b1; pressed[k] = 1'b1; press_n[k] = n;
        end else if (mask_v[k] && tick) begin
          kt = n / T - press_n[k] / T;
          if (kt == RD || (kt > RD && (kt - RD) % RR == 0)) p = 1'b1;
        end
        // Flip once DB consecutive ticks all saw the new level with no agreement between.
        if (ks[k] == old) begin
          last_agree[k] = n;
        end else if (tick && (n - (DB - 1) * T) > last_agree[k]) begin
          m_state[k]    = ~old;
          last_agree[k] = n;
        end
        m_pulse[k] = p;
      end
    end
  endtask

  initial begin
    mask_v = MASK;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("key_pulse", 32'(key_pulse), 32'(m_pulse));
      check("key_state", 32'(key_state), 32'(m_state));
      check("any_pulse", 32'(any_pulse), 32'(|m_pulse));
      for (int k = 0; k < N; k++) begin
        if (key_pulse[k]) begin
          pcnt[k]++;
          if (pcnt[k] == 1) t1[k] = n;
          if (pcnt[k] == 2) t2[k] = n;
          if (pcnt[k] == 3) t3[k] = n;
        end
      end
      if (any_pulse) begin
        any_cnt++;
        any_val = key_pulse;
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Returns just after the tick edge so the next posedge is the first to sample a change.
  task automatic align_tick();
    do cyc(1); while (n % T != 0);
  endtask

  task automatic clr();
    for (int k = 0; k < N; k++) begin
      pcnt[k] = 0; t1[k] = 0; t2[k] = 0; t3[k] = 0;
    end
    any_cnt = 0;
    any_val = '0;
  endtask

  int e;
  int idx;
  int len;

  initial begin
    rst_n = 1'b0;
    key   = '0;
    clr();
    cyc(3);
    check("reset_pulse", 32'(key_pulse), 32'h0);
    check("reset_state", 32'(key_state), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Clean press of key 3 (repeat-enabled), tick-aligned, held 300 clk.
    align_tick(); e = n; clr();
    key[3] = 1'b1;
    cyc(300);
    key[3] = 1'b0;
    cyc(39);
    check("k3_state_held", 32'(key_state[3]), 32'h1);
    cyc(1);
    check("k3_state_released", 32'(key_state[3]), 32'h0);
    cyc(20);
    check("k3_latency", 32'(t1[3] - e), 32'd41);
    check("k3_first_repeat", 32'(t2[3] - e), 32'd240);
    check("k3_second_repeat", 32'(t3[3] - e), 32'd290);
    check("k3_pulse_count", 32'(pcnt[3]), 32'd4);

    // Bounce on key 1 faster than one tick, then a steady press.
    clr();
    for (int i = 0; i < 28; i++) begin
      cyc(7);
      key[1] = ~key[1];
    end
    check("k1_bounce_pulses", 32'(pcnt[1]), 32'd0);
    check("k1_bounce_state", 32'(key_state[1]), 32'h0);
    key[1] = 1'b1;
    cyc(60);
    check("k1_steady_pulses", 32'(pcnt[1]), 32'd1);
    key[1] = 1'b0;
    cyc(60);

    // Auto-repeat on key 9 alongside non-repeating key 0, held 600 clk.
    align_tick(); e = n; clr();
    key[9] = 1'b1;
    key[0] = 1'b1;
    cyc(600);
    key[9] = 1'b0;
    key[0] = 1'b0;
    cyc(80);
    check("k9_pulse_count", 32'(pcnt[9]), 32'd10);
    check("k9_delay_gap", 32'(t2[9] - t1[9]), 32'd199);
    check("k9_rate_gap", 32'(t3[9] - t2[9]), 32'd50);
    check("k0_pulse_count", 32'(pcnt[0]), 32'd1);

    // Release during DELAY on key 6, then a fresh press must pulse again.
    align_tick(); e = n; clr();
    key[6] = 1'b1;
    cyc(141);
    key[6] = 1'b0;
    cyc(109);
    check("k6_delay_release_count", 32'(pcnt[6]), 32'd1);
    check("k6_released_state", 32'(key_state[6]), 32'h0);
    align_tick(); e = n; clr();
    key[6] = 1'b1;
    cyc(60);
    check("k6_repress_count", 32'(pcnt[6]), 32'd1);
    check("k6_repress_latency", 32'(t1[6] - e), 32'd41);
    key[6] = 1'b0;
    cyc(60);

    // Simultaneous press of keys 3 and 4.
    align_tick(); clr();
    key = key | 12'h018;
    cyc(60);
    check("simul_any_cycles", 32'(any_cnt), 32'd1);
    check("simul_pattern", 32'(any_val), 32'h018);
    key = '0;
    cyc(60);

    // Async reset mid-run with keys held, then held through reset release.
    key[3] = 1'b1;
    key[5] = 1'b1;
    cyc(80);
    check("pre_reset_state", 32'(key_state), 32'h028);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", 32'(key_state), 32'h0);
    check("async_reset_pulse", 32'(key_pulse), 32'h0);
    check("async_reset_any", 32'(any_pulse), 32'h0);
    cyc(3);
    clr();
    rst_n = 1'b1;
    cyc(40);
    check("post_reset_quiet", 32'(pcnt[3] + pcnt[5]), 32'd0);
    cyc(1);
    check("post_reset_k5_count", 32'(pcnt[5]), 32'd1);
    check("post_reset_k5_time", 32'(t1[5]), 32'd41);
    key = '0;
    cyc(60);

    // Randomized activity: held patterns and short single-key glitches.
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, N - 1);
        len = $urandom_range(1, 9);
        key[idx] = ~key[idx];
        cyc(len);
        key[idx] = ~key[idx];
        cyc($urandom_range(1, 20));
      end else begin
        key = N'($urandom);
        cyc($urandom_range(5, 320));
      end
    end
    key = '0;
    cyc(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
